// File: rtl/cpu_pkg.sv
// Shared CPU constants: fetchPC select encodings, the NOP word and the fetch FSM encoding.
// Also holds the word-alignment check used on every redirect target.
package cpu_pkg;

  localparam logic [1:0] FPC_SEQ  = 2'b00;
  localparam logic [1:0] FPC_BR   = 2'b01;
  localparam logic [1:0] FPC_JAL  = 2'b10;
  localparam logic [1:0] FPC_JALR = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [2:0] RESET_S = 3'd0;
  localparam logic [2:0] REQ     = 3'd1;
  localparam logic [2:0] HOLD    = 3'd2;
  localparam logic [2:0] DRAIN   = 3'd3;
  localparam logic [2:0] FAULT   = 3'd4;

  function automatic logic addr_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational redirect target selection and misalignment flag.
// All adds wrap modulo 2^32; jalr clears bit 0 of its sum.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [1:0]  fetch_sel,
  input  logic        branch_taken,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] redirect_imm,
  input  logic [31:0] redirect_rs1,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] seq_s;
  logic [31:0] rel_s;
  logic [31:0] jalr_s;

  assign seq_s  = redirect_pc + 32'd4;
  assign rel_s  = redirect_pc + redirect_imm;
  assign jalr_s = (redirect_rs1 + redirect_imm) & 32'hFFFF_FFFE;

  // Target mux driven by the control unit's fetchPC select.
  always_comb begin
    target = seq_s;
    case (fetch_sel)
      FPC_SEQ:  target = seq_s;
      FPC_BR: begin
        if (branch_taken) begin
          target = rel_s;
        end else begin
          target = seq_s;
        end
      end
      FPC_JAL:  target = rel_s;
      FPC_JALR: target = jalr_s;
      default:  target = seq_s;
    endcase
    misaligned = addr_misaligned(target);
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, keeps one imem request in flight and holds the
// returned word for decode. Redirects never change the address of an open request.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect_en,
  input  logic [1:0]  fetchPC,
  input  logic        branch_taken,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] redirect_imm,
  input  logic [31:0] redirect_rs1,
  output logic        fetch_fault
);

  import cpu_pkg::*;

  logic [2:0]  state_r;
  logic [2:0]  state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt_s;
  logic [31:0] pending_pc_r;
  logic [31:0] pending_nxt_s;
  logic [31:0] instr_nxt_s;
  logic [31:0] ifpc_nxt_s;
  logic [31:0] target_s;
  logic        misaligned_s;

  next_pc_calc u_next_pc_calc (
    .fetch_sel    (fetchPC),
    .branch_taken (branch_taken),
    .redirect_pc  (redirect_pc),
    .redirect_imm (redirect_imm),
    .redirect_rs1 (redirect_rs1),
    .target       (target_s),
    .misaligned   (misaligned_s)
  );

  assign imem_addr = pc_r;

  // Next-state, PC and holding-register selection.
  always_comb begin
    state_nxt_s   = state_r;
    pc_nxt_s      = pc_r;
    pending_nxt_s = pending_pc_r;
    instr_nxt_s   = if_instr;
    ifpc_nxt_s    = if_pc;
    case (state_r)
      RESET_S: begin
        if (redirect_en && misaligned_s) begin
          state_nxt_s = FAULT;
        end else if (redirect_en) begin
          pc_nxt_s    = target_s;
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = REQ;
        end
      end
      REQ: begin
        if (redirect_en) begin
          if (misaligned_s) begin
            state_nxt_s = FAULT;
          end else if (imem_ready) begin
            pc_nxt_s    = target_s;
            state_nxt_s = REQ;
          end else begin
            pending_nxt_s = target_s;
            state_nxt_s   = DRAIN;
          end
        end else if (imem_ready) begin
          instr_nxt_s = imem_rdata;
          ifpc_nxt_s  = pc_r;
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = REQ;
        end
      end
      HOLD: begin
        // A redirect wins over a same-cycle accept; the held word is dropped.
        if (redirect_en) begin
          instr_nxt_s = NOP_INSTR;
          if (misaligned_s) begin
            state_nxt_s = FAULT;
          end else begin
            pc_nxt_s    = target_s;
            state_nxt_s = REQ;
          end
        end else if (id_ready) begin
          instr_nxt_s = NOP_INSTR;
          pc_nxt_s    = pc_r + 32'd4;
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      DRAIN: begin
        if (redirect_en) begin
          if (misaligned_s) begin
            state_nxt_s = FAULT;
          end else if (imem_ready) begin
            pc_nxt_s    = target_s;
            state_nxt_s = REQ;
          end else begin
            pending_nxt_s = target_s;
            state_nxt_s   = DRAIN;
          end
        end else if (imem_ready) begin
          pc_nxt_s    = pending_pc_r;
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      FAULT: begin
        instr_nxt_s = NOP_INSTR;
        state_nxt_s = FAULT;
      end
      default: begin
        instr_nxt_s = NOP_INSTR;
        state_nxt_s = FAULT;
      end
    endcase
  end

  // State and registered outputs; output flags decode the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= RESET_S;
      pc_r         <= RESET_PC;
      pending_pc_r <= RESET_PC;
      imem_req     <= 1'b0;
      if_valid     <= 1'b0;
      if_instr     <= NOP_INSTR;
      if_pc        <= RESET_PC;
      fetch_fault  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      pending_pc_r <= pending_nxt_s;
      imem_req     <= (state_nxt_s == REQ) || (state_nxt_s == DRAIN);
      if_valid     <= (state_nxt_s == HOLD);
      if_instr     <= instr_nxt_s;
      if_pc        <= ifpc_nxt_s;
      fetch_fault  <= (state_nxt_s == FAULT);
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a redirect-target vector table applied
// from HOLD, plus hand sequences for stall, drain, wrap, fault and reset.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;
  logic        redirect_en = 1'b0;
  logic [1:0]  fetchPC = 2'b00;
  logic        branch_taken = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] redirect_imm = 32'h0;
  logic [31:0] redirect_rs1 = 32'h0;
  logic        fetch_fault;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instruction_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .id_ready     (id_ready),
    .redirect_en  (redirect_en),
    .fetchPC      (fetchPC),
    .branch_taken (branch_taken),
    .redirect_pc  (redirect_pc),
    .redirect_imm (redirect_imm),
    .redirect_rs1 (redirect_rs1),
    .fetch_fault  (fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic        taken;
    logic [31:0] rpc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] exp_addr;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ready   = 1'b0;
    imem_rdata   = 32'h0;
    id_ready     = 1'b0;
    redirect_en  = 1'b0;
    fetchPC      = 2'b00;
    branch_taken = 1'b0;
    redirect_pc  = 32'h0;
    redirect_imm = 32'h0;
    redirect_rs1 = 32'h0;
  endtask

  // Leaves the DUT in RESET_S just after rst_n is released.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    rst_n = 1'b1;
  endtask

  // Reset, then complete the first fetch at address 0; ends in HOLD.
  task automatic fetch_first(input logic [31:0] data);
    do_reset();
    step();
    imem_ready = 1'b1;
    imem_rdata = data;
    step();
    imem_ready = 1'b0;
  endtask

  task automatic set_redirect(input logic [1:0] sel, input logic taken, input logic [31:0] rpc,
                              input logic [31:0] imm, input logic [31:0] rs1);
    redirect_en  = 1'b1;
    fetchPC      = sel;
    branch_taken = taken;
    redirect_pc  = rpc;
    redirect_imm = imm;
    redirect_rs1 = rs1;
  endtask

  // Ends in REQ with imem_addr == addr (addr must be word aligned).
  task automatic go_req(input logic [31:0] addr);
    fetch_first(NOP);
    set_redirect(2'b10, 1'b0, 32'h0, addr, 32'h0);
    step();
    redirect_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'b00, 1'b0, 32'h0000_0100, 32'h0000_0040, 32'h0,         32'h0000_0104, 1'b0};
    vecs[1] = '{2'b01, 1'b1, 32'h0000_0008, 32'h0000_0020, 32'h0,         32'h0000_0028, 1'b0};
    vecs[2] = '{2'b01, 1'b0, 32'h0000_0008, 32'h0000_0020, 32'h0,         32'h0000_000C, 1'b0};
    vecs[3] = '{2'b10, 1'b0, 32'h0000_1000, 32'hFFFF_FFF0, 32'h0,         32'h0000_0FF0, 1'b0};
    vecs[4] = '{2'b11, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0203, 32'h0000_0000, 1'b1};
    vecs[5] = '{2'b11, 1'b0, 32'h0000_0000, 32'h0000_0003, 32'h0000_2001, 32'h0000_2004, 1'b0};
    vecs[6] = '{2'b10, 1'b1, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0,         32'h0000_0004, 1'b0};
    vecs[7] = '{2'b01, 1'b1, 32'h0000_0010, 32'h0000_0002, 32'h0,         32'h0000_0000, 1'b1};
    vecs[8] = '{2'b11, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0000_0101, 32'h0000_0100, 1'b0};

    // Reset values while rst_n is held low.
    clear_inputs();
    #12;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_fault", {31'h0, fetch_fault}, 32'h0);

    // First fetch, then a 5-cycle stall in HOLD, then accept.
    do_reset();
    step();
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    imem_rdata = 32'h0050_0093;
    step();
    imem_ready = 1'b0;
    chk("first_valid", {31'h0, if_valid}, 32'h1);
    chk("first_instr", if_instr, 32'h0050_0093);
    chk("first_pc", if_pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {31'h0, if_valid}, 32'h1);
      chk("stall_instr", if_instr, 32'h0050_0093);
      chk("stall_pc", if_pc, 32'h0);
      chk("stall_req", {31'h0, imem_req}, 32'h0);
    end
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    chk("accept_req", {31'h0, imem_req}, 32'h1);
    chk("accept_addr", imem_addr, 32'h4);
    chk("accept_valid", {31'h0, if_valid}, 32'h0);
    chk("accept_instr", if_instr, NOP);

    // Redirect target table, each applied in HOLD together with id_ready.
    for (int v = 0; v < 9; v++) begin
      fetch_first(32'h0000_0093);
      set_redirect(vecs[v].sel, vecs[v].taken, vecs[v].rpc, vecs[v].imm, vecs[v].rs1);
      id_ready = 1'b1;
      step();
      redirect_en = 1'b0;
      id_ready    = 1'b0;
      chk($sformatf("vec%0d_fault", v), {31'h0, fetch_fault}, {31'h0, vecs[v].exp_fault});
      chk($sformatf("vec%0d_req", v), {31'h0, imem_req}, {31'h0, ~vecs[v].exp_fault});
      chk($sformatf("vec%0d_valid", v), {31'h0, if_valid}, 32'h0);
      if (!vecs[v].exp_fault) begin
        chk($sformatf("vec%0d_addr", v), imem_addr, vecs[v].exp_addr);
      end else begin
        chk($sformatf("vec%0d_instr", v), if_instr, NOP);
      end
    end

    // Redirect while REQ at 0x40 waits for ready: address held, data discarded.
    go_req(32'h40);
    chk("drain_pre_addr", imem_addr, 32'h40);
    set_redirect(2'b10, 1'b0, 32'h0, 32'h100, 32'h0);
    step();
    redirect_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_addr", imem_addr, 32'h40);
      chk("drain_req", {31'h0, imem_req}, 32'h1);
      chk("drain_valid", {31'h0, if_valid}, 32'h0);
      if (i < 2) step();
    end
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ready = 1'b0;
    chk("drain_new_addr", imem_addr, 32'h100);
    chk("drain_new_req", {31'h0, imem_req}, 32'h1);
    chk("drain_discard_valid", {31'h0, if_valid}, 32'h0);
    chk("drain_discard_instr", if_instr, NOP);
    step();
    imem_ready = 1'b1;
    imem_rdata = 32'h00A0_0113;
    step();
    imem_ready = 1'b0;
    chk("drain_fetch_valid", {31'h0, if_valid}, 32'h1);
    chk("drain_fetch_instr", if_instr, 32'h00A0_0113);
    chk("drain_fetch_pc", if_pc, 32'h100);

    // Second redirect during DRAIN: newest target wins.
    go_req(32'h40);
    set_redirect(2'b10, 1'b0, 32'h0, 32'h100, 32'h0);
    step();
    set_redirect(2'b10, 1'b0, 32'h0, 32'h300, 32'h0);
    step();
    redirect_en = 1'b0;
    chk("drain2_addr", imem_addr, 32'h40);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    chk("drain2_new_addr", imem_addr, 32'h300);

    // Redirect in the same cycle as ready in REQ.
    go_req(32'h40);
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0BAD;
    set_redirect(2'b10, 1'b0, 32'h0, 32'h200, 32'h0);
    step();
    clear_inputs();
    chk("reqrdy_addr", imem_addr, 32'h200);
    chk("reqrdy_req", {31'h0, imem_req}, 32'h1);
    chk("reqrdy_valid", {31'h0, if_valid}, 32'h0);

    // PC wrap from 0xFFFFFFFC.
    go_req(32'hFFFF_FFFC);
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0013;
    step();
    imem_ready = 1'b0;
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_fault", {31'h0, fetch_fault}, 32'h0);
    chk("wrap_req", {31'h0, imem_req}, 32'h1);

    // Misaligned jalr: fault is sticky until reset.
    fetch_first(32'h0000_0013);
    set_redirect(2'b11, 1'b0, 32'h0, 32'h0, 32'h203);
    step();
    set_redirect(2'b10, 1'b0, 32'h0, 32'h80, 32'h0);
    imem_ready = 1'b1;
    id_ready   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fault_sticky", {31'h0, fetch_fault}, 32'h1);
      chk("fault_req", {31'h0, imem_req}, 32'h0);
      chk("fault_valid", {31'h0, if_valid}, 32'h0);
    end
    clear_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk("fault_cleared", {31'h0, fetch_fault}, 32'h0);

    // Reset asserted mid-request returns outputs immediately.
    go_req(32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreq_req", {31'h0, imem_req}, 32'h0);
    chk("midreq_addr", imem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
